bnn_cmd_sequencer: RTL and testbench
====================================

Name: bnn_cmd_sequencer

Overview:
Command sequencer between the UART byte receiver/transmitter and the BNN inference engine. It parses single-byte commands from the host, streams image bytes into the engine's image buffer, launches inference and waits for completion. It returns one response byte per command through a valid/ready transmit interface, and drives UART flow control (CTS).

Parameters:
IMG_BYTES, 72, number of image payload bytes per LOAD (24x24 binary image)
ADDR_W, 7, image buffer address width; IMG_BYTES <= 2**ADDR_W
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between LOAD payload bytes, and maximum RUN wait
CNT_W, 20, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_cts  out  1  clear-to-send to host; high when a byte will be accepted
tx_data  out  8  response byte
tx_valid  out  1  response valid; held until tx_ready
tx_ready  in  1  UART transmitter can accept byte
img_wr_en  out  1  image buffer write strobe
img_wr_addr  out  ADDR_W  image buffer write address
img_wr_data  out  8  image buffer write data
bnn_start  out  1  one-cycle inference start pulse
bnn_busy  in  1  engine busy
bnn_done  in  1  one-cycle inference-complete strobe
bnn_result  in  4  predicted class; valid in the bnn_done cycle
status  out  3  {img_loaded, overrun, timeout_err}, sticky flags

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 except rx_cts=1. Counters and flags clear; img_loaded=0.
- States: IDLE, LOAD, RUN_START, RUN_WAIT, SEND.
- IDLE: on rx_valid, decode rx_data:
  - 0xA1 LOAD: go to LOAD; addr=0; img_loaded cleared.
  - 0xA2 RUN: if img_loaded=1 and bnn_busy=0, go to RUN_START. Otherwise queue NAK 0xEE and go to SEND.
  - 0xA3 STATUS: queue {5'b10100, img_loaded, overrun, timeout_err}, go to SEND. Clear overrun and timeout_err in the same cycle the byte is queued.
  - Any other value: queue NAK 0xEE, go to SEND.
- LOAD: each rx_valid gives img_wr_en=1 in the next cycle, with img_wr_addr=addr and img_wr_data=byte (1-cycle registered latency). Then addr increments.
  - After byte IMG_BYTES-1 is written: img_loaded=1, queue ACK 0x55, go to SEND.
  - Idle timeout: counter resets on every rx_valid. When it reaches TIMEOUT_CYCLES, set timeout_err, leave img_loaded=0, queue NAK 0xEE, go to SEND. Partial writes are not undone.
- RUN_START: bnn_start=1 for exactly one cycle, then RUN_WAIT.
- RUN_WAIT:
  - On bnn_done: queue {4'hC, bnn_result}, go to SEND.
  - No bnn_done within TIMEOUT_CYCLES: set timeout_err, queue 0xEE, go to SEND.
  - img_loaded remains 1, so RUN may be repeated.
- SEND: tx_valid=1 with tx_data stable until the cycle tx_valid and tx_ready are both high. The next cycle has tx_valid=0, state IDLE. The tx_ready level before entering SEND has no effect.
- rx_cts = 1 in IDLE and LOAD, 0 otherwise. A byte arriving with rx_valid while not in IDLE/LOAD is dropped and sets overrun.
- In the last LOAD byte cycle the byte is consumed normally; no extra byte is accepted.
- A bnn_done outside RUN_WAIT is ignored.
- Reset mid-operation aborts immediately. No pending tx byte survives; img_loaded=0.
- Exactly one response byte per accepted command.

Test Plan:
- Reset, then STATUS 0xA3 -> tx_data 0xA0; rx_cts=1; all img_wr_en/bnn_start remain 0.
- LOAD 0xA1 + 72 bytes 0x00..0x47 -> 72 writes at addr 0..71 with data=addr, each one cycle after rx_valid; then tx 0x55; status[2]=1.
- After LOAD, RUN 0xA2; model asserts bnn_done with result 7 after 50 cycles -> one bnn_start pulse, rx_cts=0 during wait, tx 0xC7; tx held 5 cycles with tx_ready=0 then accepted once.
- RUN right after reset -> tx 0xEE, no bnn_start. Unknown byte 0x42 -> tx 0xEE.
- LOAD with only 10 bytes then silence (TIMEOUT_CYCLES=100) -> tx 0xEE at timeout. Following STATUS returns 0xA1; the next STATUS returns 0xA0.
- Byte sent during RUN_WAIT -> dropped, no write. STATUS afterwards returns 0xA6 (img_loaded, overrun). Assert rst low mid-LOAD -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/bnn_cmd_sequencer.sv
// Host command sequencer for the BNN engine: parses UART command bytes, streams the
// image into the engine buffer, launches inference and returns one response byte per command.
module bnn_cmd_sequencer #(
  parameter int IMG_BYTES      = 72,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_cts,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_img_wr_en,
  output logic [ADDR_W-1:0] o_img_wr_addr,
  output logic [7:0]        o_img_wr_data,
  output logic              o_bnn_start,
  input  logic              i_bnn_busy,
  input  logic              i_bnn_done,
  input  logic [3:0]        i_bnn_result,
  output logic [2:0]        o_status
);

  localparam logic [7:0] CMD_LOAD   = 8'hA1;
  localparam logic [7:0] CMD_RUN    = 8'hA2;
  localparam logic [7:0] CMD_STATUS = 8'hA3;
  localparam logic [7:0] RSP_ACK    = 8'h55;
  localparam logic [7:0] RSP_NAK    = 8'hEE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_START,
    S_RUN_WAIT,
    S_SEND
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_loaded;
  logic              r_overrun;
  logic              r_timeout;
  logic [7:0]        r_tx_data;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_loaded_nxt;
  logic              w_overrun_nxt;
  logic              w_timeout_nxt;
  logic [7:0]        w_tx_data_nxt;
  logic              w_wr_en_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [7:0]        w_wr_data_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_loaded  <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_tx_data <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_loaded  <= w_loaded_nxt;
      r_overrun <= w_overrun_nxt;
      r_timeout <= w_timeout_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_loaded_nxt  = r_loaded;
    w_overrun_nxt = r_overrun;
    w_timeout_nxt = r_timeout;
    w_tx_data_nxt = r_tx_data;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;

    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              w_state_nxt  = S_LOAD;
              w_addr_nxt   = '0;
              w_cnt_nxt    = '0;
              w_loaded_nxt = 1'b0;
            end
            CMD_RUN: begin
              if (r_loaded && !i_bnn_busy) begin
                w_state_nxt = S_RUN_START;
                w_cnt_nxt   = '0;
              end else begin
                w_tx_data_nxt = RSP_NAK;
                w_state_nxt   = S_SEND;
              end
            end
            CMD_STATUS: begin
              w_tx_data_nxt = {5'b10100, r_loaded, r_overrun, r_timeout};
              w_overrun_nxt = 1'b0;
              w_timeout_nxt = 1'b0;
              w_state_nxt   = S_SEND;
            end
            default: begin
              w_tx_data_nxt = RSP_NAK;
              w_state_nxt   = S_SEND;
            end
          endcase
        end
      end

      // Write is registered, so it lands one cycle after the byte, even on the final byte.
      S_LOAD: begin
        if (i_rx_valid) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_addr;
          w_wr_data_nxt = i_rx_data;
          w_addr_nxt    = r_addr + 1'b1;
          w_cnt_nxt     = '0;
          if (r_addr == LAST_ADDR) begin
            w_loaded_nxt  = 1'b1;
            w_tx_data_nxt = RSP_ACK;
            w_state_nxt   = S_SEND;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_tx_data_nxt = RSP_NAK;
          w_state_nxt   = S_SEND;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_RUN_START: begin
        w_state_nxt = S_RUN_WAIT;
      end

      S_RUN_WAIT: begin
        if (i_bnn_done) begin
          w_tx_data_nxt = {4'hC, i_bnn_result};
          w_state_nxt   = S_SEND;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_tx_data_nxt = RSP_NAK;
          w_state_nxt   = S_SEND;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_SEND: begin
        if (i_tx_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // CTS is low here, so any byte the host still pushes is lost.
    if (i_rx_valid && (r_state != S_IDLE) && (r_state != S_LOAD)) begin
      w_overrun_nxt = 1'b1;
    end
  end

  assign o_rx_cts      = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign o_tx_valid    = (r_state == S_SEND);
  assign o_tx_data     = r_tx_data;
  assign o_bnn_start   = (r_state == S_RUN_START);
  assign o_img_wr_en   = r_wr_en;
  assign o_img_wr_addr = r_wr_addr;
  assign o_img_wr_data = r_wr_data;
  assign o_status      = {r_loaded, r_overrun, r_timeout};

endmodule

// File: tb/tb_bnn_cmd_sequencer.sv
// Randomised self-checking bench for bnn_cmd_sequencer with a behavioural engine and
// a flag-level model of the host-visible protocol.
`timescale 1ns/1ps
module tb_bnn_cmd_sequencer;

  localparam int IMG_BYTES = 72;
  localparam int ADDR_W    = 7;
  localparam int TIMEOUT   = 100;
  localparam int WAIT_MAX  = 600;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_cts;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              img_wr_en;
  logic [ADDR_W-1:0] img_wr_addr;
  logic [7:0]        img_wr_data;
  logic              bnn_start;
  logic              bnn_busy = 1'b0;
  logic              bnn_done = 1'b0;
  logic [3:0]        bnn_result = '0;
  logic [2:0]        status;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int start_count = 0;
  bit eng_enable = 1'b1;
  int eng_delay = 10;
  logic [3:0] eng_result = '0;

  // Host-visible model state
  bit model_loaded = 1'b0;
  bit model_ovr = 1'b0;
  bit model_to = 1'b0;

  bnn_cmd_sequencer #(
    .IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(20)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_cts(rx_cts),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_img_wr_en(img_wr_en), .o_img_wr_addr(img_wr_addr), .o_img_wr_data(img_wr_data),
    .o_bnn_start(bnn_start), .i_bnn_busy(bnn_busy), .i_bnn_done(bnn_done),
    .i_bnn_result(bnn_result), .o_status(status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (img_wr_en === 1'b1) wr_count++;
    if (bnn_start === 1'b1) start_count++;
  end

  // Behavioural inference engine: busy for eng_delay cycles, then one done strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (bnn_start === 1'b1 && eng_enable) begin
        bnn_busy = 1'b1;
        repeat (eng_delay) @(negedge clk);
        bnn_result = eng_result;
        bnn_done = 1'b1;
        @(negedge clk);
        bnn_done = 1'b0;
        bnn_busy = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_load(input int n, input bit rand_data);
    send_byte(8'hA1);
    for (int i = 0; i < n; i++) send_byte(rand_data ? 8'($urandom) : 8'(i));
  endtask

  task automatic recv_tx(input int hold, output logic [7:0] b, output bit seen,
                         output bit stable, output bit dropped);
    seen = 1'b0; stable = 1'b1; dropped = 1'b0; b = 'x;
    for (int i = 0; i < WAIT_MAX && !seen; i++) begin
      if (tx_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) return;
    b = tx_data;
    tx_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== b) stable = 1'b0;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    dropped = (tx_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_cts, tx_valid, img_wr_en, bnn_start, status, tx_data} !== {4'b1000, 3'b000, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got cts=%b txv=%b we=%b st=%b status=%b tx=%h, expected cts=1 others 0",
               rx_cts, tx_valid, img_wr_en, bnn_start, status, tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_status_after_reset();
    logic [7:0] b; bit seen, stable, dropped;
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA0) begin
      errors++; $display("[TB] FAIL status_after_reset: got %h (seen=%b) expected a0", b, seen);
    end
    checks++;
    if (rx_cts !== 1'b1 || wr_count !== 0 || start_count !== 0) begin
      errors++;
      $display("[TB] FAIL idle_quiet: got cts=%b writes=%0d starts=%0d expected 1/0/0", rx_cts, wr_count, start_count);
    end
  endtask

  task automatic test_nak();
    logic [7:0] b; bit seen, stable, dropped;
    send_byte(8'hA2);
    recv_tx(1, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hEE || start_count !== 0) begin
      errors++; $display("[TB] FAIL run_unloaded: got %h starts=%0d expected ee starts=0", b, start_count);
    end
    send_byte(8'h42);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hEE) begin
      errors++; $display("[TB] FAIL unknown_cmd: got %h expected ee", b);
    end
  endtask

  task automatic test_load();
    logic [7:0] b; bit seen, stable, dropped;
    int bad = 0;
    send_byte(8'hA1);
    for (int i = 0; i < IMG_BYTES; i++) begin
      send_byte(8'(i));
      if (img_wr_en !== 1'b1 || img_wr_addr !== ADDR_W'(i) || img_wr_data !== 8'(i)) begin
        if (bad == 0)
          $display("[TB] FAIL load_write: byte %0d got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                   i, img_wr_en, img_wr_addr, img_wr_data, i, 8'(i));
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'h55 || status[2] !== 1'b1) begin
      errors++; $display("[TB] FAIL load_ack: got %h status=%b expected 55 with status[2]=1", b, status);
    end
    model_loaded = 1'b1;
  endtask

  task automatic test_run();
    logic [7:0] b; bit seen, stable, dropped;
    int s0 = start_count;
    eng_delay = 50; eng_result = 4'd7;
    send_byte(8'hA2);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_cts !== 1'b0) begin
      errors++; $display("[TB] FAIL cts_in_run: got %b expected 0", rx_cts);
    end
    recv_tx(5, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hC7) begin
      errors++; $display("[TB] FAIL run_result: got %h expected c7", b);
    end
    checks++;
    if (!stable || !dropped || start_count - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL run_handshake: got stable=%b released=%b starts=%0d expected 1/1/1",
               stable, dropped, start_count - s0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b; bit seen, stable, dropped;
    int w0 = wr_count;
    eng_delay = 50; eng_result = 4'($urandom);
    send_byte(8'hA2);
    repeat (10) @(negedge clk);
    send_byte(8'h33);
    recv_tx(2, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== {4'hC, eng_result} || wr_count !== w0) begin
      errors++;
      $display("[TB] FAIL overrun_run: got %h writes=%0d expected %h writes=%0d", b, wr_count, {4'hC, eng_result}, w0);
    end
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA6) begin
      errors++; $display("[TB] FAIL overrun_status: got %h expected a6", b);
    end
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA4) begin
      errors++; $display("[TB] FAIL overrun_cleared: got %h expected a4", b);
    end
  endtask

  task automatic test_run_timeout();
    logic [7:0] b; bit seen, stable, dropped;
    eng_enable = 1'b0;
    send_byte(8'hA2);
    recv_tx(0, b, seen, stable, dropped);
    eng_enable = 1'b1;
    checks++;
    if (!seen || b !== 8'hEE) begin
      errors++; $display("[TB] FAIL run_timeout: got %h (seen=%b) expected ee", b, seen);
    end
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA5) begin
      errors++; $display("[TB] FAIL run_timeout_status: got %h expected a5", b);
    end
  endtask

  task automatic test_load_timeout();
    logic [7:0] b; bit seen, stable, dropped;
    do_load(10, 1'b0);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hEE) begin
      errors++; $display("[TB] FAIL load_timeout: got %h (seen=%b) expected ee", b, seen);
    end
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA1) begin
      errors++; $display("[TB] FAIL load_timeout_status: got %h expected a1", b);
    end
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA0) begin
      errors++; $display("[TB] FAIL status_second: got %h expected a0", b);
    end
    model_loaded = 1'b0; model_ovr = 1'b0; model_to = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] b, exp, cmd; bit seen, stable, dropped;
    int exp_starts = start_count;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          do_load(IMG_BYTES, 1'b1);
          exp = 8'h55; model_loaded = 1'b1;
        end
        1: begin
          eng_delay = $urandom_range(6, 30);
          eng_result = 4'($urandom);
          send_byte(8'hA2);
          if (model_loaded) begin
            exp = {4'hC, eng_result};
            exp_starts++;
            if ($urandom_range(0, 1) == 1) begin
              repeat (2) @(negedge clk);
              send_byte(8'($urandom));
              model_ovr = 1'b1;
            end
          end else begin
            exp = 8'hEE;
          end
        end
        2: begin
          send_byte(8'hA3);
          exp = {5'b10100, model_loaded, model_ovr, model_to};
          model_ovr = 1'b0; model_to = 1'b0;
        end
        default: begin
          do cmd = 8'($urandom); while (cmd inside {8'hA1, 8'hA2, 8'hA3});
          send_byte(cmd);
          exp = 8'hEE;
        end
      endcase
      recv_tx($urandom_range(0, 3), b, seen, stable, dropped);
      checks++;
      if (!seen || b !== exp || !stable || !dropped) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h seen=%b stable=%b released=%b expected %h",
                 it, b, seen, stable, dropped, exp);
      end
    end
    checks++;
    if (start_count !== exp_starts) begin
      errors++; $display("[TB] FAIL random_starts: got %0d expected %0d", start_count, exp_starts);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b; bit seen, stable, dropped;
    do_load(5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_cts, tx_valid, img_wr_en, bnn_start, status, img_wr_addr} !== {4'b1000, 3'b000, 7'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got cts=%b txv=%b we=%b st=%b status=%b addr=%0d expected cts=1 others 0",
               rx_cts, tx_valid, img_wr_en, bnn_start, status, img_wr_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hA3);
    recv_tx(0, b, seen, stable, dropped);
    checks++;
    if (!seen || b !== 8'hA0) begin
      errors++; $display("[TB] FAIL status_after_abort: got %h expected a0", b);
    end
  endtask

  initial begin
    test_reset();
    test_status_after_reset();
    test_nak();
    test_load();
    test_run();
    test_overrun();
    test_run_timeout();
    test_load_timeout();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
